// File: rtl/simple_stim_driver.sv
// Stimulus driver and response checker for the falling-edge `simple` toggle cell:
// drives LFSR vectors, models the cell cycle-accurately and counts output mismatches.
module simple_stim_driver #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             tau2015_clk,
    input  logic             tau2015_rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             out_fb,
    output logic             inp1,
    output logic             inp2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d, lfsr_adv;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic             pass_q, pass_d;
    logic             exp_q, exp_d;
    logic             inp1_q, inp1_d;
    logic             inp2_q, inp2_d;
    logic             exp_next, last_vec;

    assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign exp_next = inp1_q & inp2_q & ~exp_q;
    assign last_vec = (idx_q == (len_q - ONE));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        len_d           = len_q;
        idx_d           = idx_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vld_d = first_err_vld_q;
        pass_d          = pass_q;
        exp_d           = exp_q;
        inp1_d          = 1'b0;
        inp2_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d           = burst_len;
                    lfsr_d          = SEED;
                    idx_d           = '0;
                    err_cnt_d       = '0;
                    first_err_idx_d = '0;
                    first_err_vld_d = 1'b0;
                    pass_d          = 1'b0;
                    state_d         = S_PRIME;
                end
            end
            S_PRIME: begin
                // Inputs held low this cycle flush the unreset cell flop to 0.
                exp_d = 1'b0;
                if (len_q != '0) begin
                    inp1_d  = lfsr_q[0];
                    inp2_d  = lfsr_q[1];
                    state_d = S_RUN;
                end else begin
                    pass_d  = (err_cnt_q == '0);
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                exp_d  = exp_next;
                lfsr_d = lfsr_adv;
                idx_d  = idx_q + ONE;
                if (out_fb != exp_next) begin
                    err_cnt_d = err_cnt_q + ONE;
                    if (!first_err_vld_q) begin
                        first_err_vld_d = 1'b1;
                        first_err_idx_d = idx_q;
                    end
                end
                if (last_vec) begin
                    pass_d  = (err_cnt_d == '0);
                    state_d = S_DONE;
                end else begin
                    inp1_d = lfsr_adv[0];
                    inp2_d = lfsr_adv[1];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            state_q         <= S_IDLE;
            lfsr_q          <= SEED;
            len_q           <= '0;
            idx_q           <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
            exp_q           <= 1'b0;
            inp1_q          <= 1'b0;
            inp2_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vld_q <= first_err_vld_d;
            pass_q          <= pass_d;
            exp_q           <= exp_d;
            inp1_q          <= inp1_d;
            inp2_q          <= inp2_d;
        end
    end

    assign inp1          = inp1_q;
    assign inp2          = inp2_q;
    assign busy          = (state_q == S_PRIME) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_simple_stim_driver.sv
// Self-checking bench for simple_stim_driver: a behavioural falling-edge cell closes the loop,
// with optional per-vector output inversion to provoke known mismatches.
module tb_simple_stim_driver;

    localparam int          CNT_W = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             start     = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             flip      = 1'b0;
    logic             cell_q;
    logic             out_fb;
    logic             inp1, inp2, busy, done, pass, first_err_vld;
    logic [CNT_W-1:0] err_cnt, first_err_idx;

    int n_cmp = 0;
    int n_err = 0;

    simple_stim_driver #(.CNT_W(CNT_W), .LFSR_SEED(SEED)) dut (
        .tau2015_clk   (clk),
        .tau2015_rst_n (rst_n),
        .start         (start),
        .burst_len     (burst_len),
        .out_fb        (out_fb),
        .inp1          (inp1),
        .inp2          (inp2),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    // Unreset toggle cell capturing on the falling edge; flip injects output faults.
    always @(negedge clk) cell_q <= inp1 & inp2 & ~cell_q;
    assign out_fb = cell_q ^ flip;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic b, input logic d, input logic i1,
                             input logic i2, input logic p, input int ec, input logic v,
                             input int idx);
        check({tag, "_busy"}, busy, b);
        check({tag, "_done"}, done, d);
        check({tag, "_inp1"}, inp1, i1);
        check({tag, "_inp2"}, inp2, i2);
        check({tag, "_pass"}, pass, p);
        check({tag, "_err_cnt"}, err_cnt, ec);
        check({tag, "_first_vld"}, first_err_vld, v);
        check({tag, "_first_idx"}, first_err_idx, idx);
    endtask

    // Entered and left at posedge+1. mask[k] inverts the cell output during vector k;
    // noise wiggles start/burst_len while the run is in progress.
    task automatic do_run(input int len, input logic [63:0] mask, input bit noise);
        logic [15:0] l;
        bit          va[64];
        bit          vb[64];
        int          exp_err;
        int          exp_idx;
        bit          exp_vld;
        l       = SEED;
        exp_err = 0;
        exp_idx = 0;
        exp_vld = 1'b0;
        for (int k = 0; k < len; k++) begin
            va[k] = l[0];
            vb[k] = l[1];
            l     = lfsr_step(l);
            if (mask[k]) begin
                exp_err++;
                if (!exp_vld) begin
                    exp_vld = 1'b1;
                    exp_idx = k;
                end
            end
        end

        start     = 1'b1;
        burst_len = CNT_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        check_all("prime", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            check("vec_inp1", inp1, va[k]);
            check("vec_inp2", inp2, vb[k]);
            check("vec_busy", busy, 1'b1);
            check("vec_done", done, 1'b0);
            flip = mask[k];
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                burst_len = CNT_W'($urandom);
            end
        end

        @(posedge clk); #1;
        flip  = 1'b0;
        start = noise;  // a start held through DONE must be ignored
        check_all("done", 1'b0, 1'b1, 1'b0, 1'b0, exp_err == 0, exp_err, exp_vld, exp_idx);

        @(posedge clk); #1;
        start = 1'b0;
        check_all("hold", 1'b0, 1'b0, 1'b0, 1'b0, exp_err == 0, exp_err, exp_vld, exp_idx);
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved.
        #2 rst_n = 1'b0;
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

        do_run(4, 64'h0, 1'b0);            // ideal cell
        do_run(8, 64'h4, 1'b0);            // single fault on vector 2
        do_run(8, '1, 1'b0);               // stuck at inverted expectation

        // Mid-cycle reset must clear held results before the next edge.
        #3 rst_n = 1'b0;
        #1;
        check_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_run(0, 64'h0, 1'b1);            // empty burst
        do_run(8, 64'h0A, 1'b1);           // start/burst_len noise during RUN

        // Abort during vector 3 of an 8-vector run; no done may follow.
        start     = 1'b1;
        burst_len = CNT_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst_n = 1'b1;
            check("abort_no_done", done, 1'b0);
            check("abort_no_busy", busy, 1'b0);
        end
        do_run(8, 64'h0, 1'b0);            // restart reproduces the sequence from vector 0

        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 48)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
